// File: rtl/vproc_cache_arbiter.sv
// vproc_cache_arbiter
//
// Two-requester arbiter in front of the single CPU-side port of the vproc
// data cache (requester 0: scalar LSU, requester 1: vector LSU). It forwards
// one request per cycle with the req/gnt/rvalid handshake. It records the
// owner of every accepted transaction in an in-order ID FIFO, and routes each
// cache response back to that owner with zero latency.
//
// Arbitration is round-robin. A request that is presented but not granted is
// locked, so the cache sees a stable request until it is accepted.
//
// Build option:
//   VPROC_CACHE_ARB_FIXED_PRIO_EN  requester 0 always wins a tie when no lock
//                                  is held (no round-robin pointer). Locking is
//                                  unchanged.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i/addr_i/we_i/be_i/wdata_i requester side, slice n = requester n
//   gnt_o, rvalid_o               per-requester grant / response valid
//   rdata_o, err_o                shared response data / error (qualified
//                                 by rvalid_o)
//   cache_req_o ... cache_wdata_o request to the cache
//   cache_gnt_i, cache_rvalid_i,
//   cache_rdata_i, cache_err_i    cache handshake and response
module vproc_cache_arbiter #(
  parameter int unsigned ADDR_BIT_W      = 32,
  parameter int unsigned DATA_BYTE_W     = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   req_i,
  input  logic [2*ADDR_BIT_W-1:0]      addr_i,
  input  logic [1:0]                   we_i,
  input  logic [2*DATA_BYTE_W-1:0]     be_i,
  input  logic [2*DATA_BYTE_W*8-1:0]   wdata_i,
  output logic [1:0]                   gnt_o,
  output logic [1:0]                   rvalid_o,
  output logic [DATA_BYTE_W*8-1:0]     rdata_o,
  output logic                         err_o,
  output logic                         cache_req_o,
  output logic [ADDR_BIT_W-1:0]        cache_addr_o,
  output logic                         cache_we_o,
  output logic [DATA_BYTE_W-1:0]       cache_be_o,
  output logic [DATA_BYTE_W*8-1:0]     cache_wdata_o,
  input  logic                         cache_gnt_i,
  input  logic                         cache_rvalid_i,
  input  logic [DATA_BYTE_W*8-1:0]     cache_rdata_i,
  input  logic                         cache_err_i
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned DATA_W = DATA_BYTE_W * 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]           count_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q;
  logic                       lock_valid_q;
  logic                       lock_id_q;
  logic                       spurious_q;
`ifndef VPROC_CACHE_ARB_FIXED_PRIO_EN
  logic                       prio_q;
`endif

  logic sel;
  logic full;
  logic accept;
  logic pop;
  logic head_id;

  // Requester selection: a held lock always wins, then a lone requester,
  // then the tie-break.
  always_comb begin
    sel = 1'b0;
    if (lock_valid_q) begin
      sel = lock_id_q;
    end else if (req_i == 2'b10) begin
      sel = 1'b1;
`ifndef VPROC_CACHE_ARB_FIXED_PRIO_EN
    end else if (req_i == 2'b11) begin
      sel = prio_q;
`endif
    end
  end

  // No pop-bypass when full: a response in the same cycle does not free the
  // slot early.
  assign full        = (count_q == CNT_MAX);
  assign cache_req_o = req_i[sel] & ~full;
  assign accept      = cache_req_o & cache_gnt_i;

  assign cache_addr_o  = sel ? addr_i[2*ADDR_BIT_W-1:ADDR_BIT_W]   : addr_i[ADDR_BIT_W-1:0];
  assign cache_we_o    = sel ? we_i[1]                             : we_i[0];
  assign cache_be_o    = sel ? be_i[2*DATA_BYTE_W-1:DATA_BYTE_W]   : be_i[DATA_BYTE_W-1:0];
  assign cache_wdata_o = sel ? wdata_i[2*DATA_W-1:DATA_W]          : wdata_i[DATA_W-1:0];

  assign gnt_o = {accept & sel, accept & ~sel};

  // Responses arrive in acceptance order, so the FIFO head names the owner.
  // A response with nothing outstanding is dropped.
  assign pop      = cache_rvalid_i & (count_q != '0);
  assign head_id  = id_fifo_q[rd_ptr_q];
  assign rvalid_o = {pop & head_id, pop & ~head_id};
  assign rdata_o  = cache_rdata_i;
  assign err_o    = cache_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      id_fifo_q <= '0;
    end else begin
      if (accept) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (accept && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !accept) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Lock whenever the selected requester is still asking but was not
  // accepted (cache stall or full FIFO); drop it on accept or when the
  // locked requester withdraws.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
    end else if (accept) begin
      lock_valid_q <= 1'b0;
    end else if (req_i[sel]) begin
      lock_valid_q <= 1'b1;
      lock_id_q    <= sel;
    end else begin
      lock_valid_q <= 1'b0;
    end
  end

`ifndef VPROC_CACHE_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= ~sel;
    end
  end
`endif

  // Sticky debug flag for responses that had no outstanding owner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spurious_q <= 1'b0;
    end else if (cache_rvalid_i && count_q == '0) begin
      spurious_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vproc_cache_arbiter.sv
// Testbench for vproc_cache_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_vproc_cache_arbiter;

  localparam int AW  = 32;
  localparam int DB  = 4;
  localparam int DW  = DB * 8;
  localparam int MAX = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [1:0]    req = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [1:0]    we = '0;
  logic [DB-1:0] be0 = '0, be1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          cgnt = 1'b0, crv = 1'b0, cerr = 1'b0;
  logic [DW-1:0] crdata = '0;

  logic [1:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic          cache_req_o;
  logic [AW-1:0] cache_addr_o;
  logic          cache_we_o;
  logic [DB-1:0] cache_be_o;
  logic [DW-1:0] cache_wdata_o;

  vproc_cache_arbiter #(
    .ADDR_BIT_W(AW), .DATA_BYTE_W(DB), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req), .addr_i({addr1, addr0}), .we_i(we),
    .be_i({be1, be0}), .wdata_i({wdata1, wdata0}),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .cache_req_o(cache_req_o), .cache_addr_o(cache_addr_o),
    .cache_we_o(cache_we_o), .cache_be_o(cache_be_o),
    .cache_wdata_o(cache_wdata_o),
    .cache_gnt_i(cgnt), .cache_rvalid_i(crv),
    .cache_rdata_i(crdata), .cache_err_i(cerr)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding owners kept as a plain queue.
  int   owners[$];
  bit   m_prio, m_lock_v, m_lock_id;
  logic m_sel, exp_creq;
  logic [1:0] exp_gnt, exp_rv;

  task automatic model_reset();
    owners.delete();
    m_prio = 0; m_lock_v = 0; m_lock_id = 0;
  endtask

  task automatic predict();
    if (m_lock_v) m_sel = m_lock_id;
    else if (req == 2'b10) m_sel = 1'b1;
    else if (req == 2'b11) begin
`ifdef VPROC_CACHE_ARB_FIXED_PRIO_EN
      m_sel = 1'b0;
`else
      m_sel = m_prio;
`endif
    end else m_sel = 1'b0;
    exp_creq = req[m_sel] && (owners.size() < MAX);
    exp_gnt  = (exp_creq && cgnt) ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
    exp_rv   = (crv && owners.size() > 0) ? (owners[0] == 1 ? 2'b10 : 2'b01) : 2'b00;
  endtask

  task automatic advance();
    bit acc;
    predict();
    @(posedge clk_i);
    acc = exp_creq && cgnt;
    if (crv && owners.size() > 0) void'(owners.pop_front());
    if (acc) begin
      owners.push_back(int'(m_sel));
      m_prio   = ~m_sel;
      m_lock_v = 0;
    end else if (req[m_sel]) begin
      m_lock_v  = 1;
      m_lock_id = m_sel;
    end else begin
      m_lock_v = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; cgnt = 0; crv = 0; cerr = 0; crdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    addr0 = '0; addr1 = '0; we = '0; be0 = '0; be1 = '0; wdata0 = '0; wdata1 = '0;
    rst_ni = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({gnt_o, rvalid_o, err_o, cache_req_o, cache_we_o} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {gnt_o, rvalid_o, err_o, cache_req_o, cache_we_o});
    end
    n_checks++;
    if ({rdata_o, cache_addr_o, cache_be_o, cache_wdata_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {rdata_o, cache_addr_o, cache_be_o, cache_wdata_o});
    end
    n_checks++;
    if (dut.spurious_q !== 1'b0) begin
      n_fail++; $display("FAIL reset_spurious: got %b expected 0", dut.spurious_q);
    end
    @(posedge clk_i); #1;
    rst_ni = 1;
  endtask

  task automatic test_single();
    req = 2'b01; addr0 = 32'h1000; addr1 = 32'h2000; cgnt = 1;
    @(negedge clk_i);
    n_checks++;
    if (gnt_o !== 2'b01 || cache_addr_o !== 32'h1000 || cache_req_o !== 1'b1) begin
      n_fail++; $display("FAIL single_gnt: got gnt=%b addr=%h req=%b expected 01 00001000 1", gnt_o, cache_addr_o, cache_req_o);
    end
    advance();
    req = 2'b00; cgnt = 0; crv = 1; crdata = 32'hDEADBEEF;
    @(negedge clk_i);
    n_checks++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_resp: got rv=%b data=%h expected 01 deadbeef", rvalid_o, rdata_o);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [4];
`ifdef VPROC_CACHE_ARB_FIXED_PRIO_EN
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    // Previous accept came from requester 0, so requester 1 is favoured.
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    req = 2'b11; cgnt = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (gnt_o !== exp_seq[i]) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt_o, exp_seq[i]);
      end
      advance();
    end
    idle_inputs();
    crv = 1;
    for (int i = 0; i < 4; i++) begin
      crdata = $urandom;
      @(negedge clk_i);
      n_checks++;
      if (rvalid_o !== exp_seq[i]) begin
        n_fail++; $display("FAIL rr_resp[%0d]: got %b expected %b", i, rvalid_o, exp_seq[i]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    addr0 = 32'hA000_0000; addr1 = 32'hB000_0004;
    req = 2'b10; cgnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) req = 2'b11;
      if (i == 3) cgnt = 1;
      @(negedge clk_i);
      n_checks++;
      if (cache_addr_o !== 32'hB000_0004 || cache_req_o !== 1'b1) begin
        n_fail++; $display("FAIL lock_addr[%0d]: got %h req=%b expected b0000004 1", i, cache_addr_o, cache_req_o);
      end
      n_checks++;
      if (gnt_o !== ((i == 3) ? 2'b10 : 2'b00)) begin
        n_fail++; $display("FAIL lock_gnt[%0d]: got %b expected %b", i, gnt_o, (i == 3) ? 2'b10 : 2'b00);
      end
      advance();
    end
    idle_inputs();
    crv = 1;
    @(negedge clk_i);
    n_checks++;
    if (rvalid_o !== 2'b10) begin
      n_fail++; $display("FAIL lock_resp: got %b expected 10", rvalid_o);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_full();
    logic [1:0] ids [4];
    ids = '{2'b01, 2'b10, 2'b10, 2'b01};
    cgnt = 1;
    for (int i = 0; i < 4; i++) begin
      req = ids[i];
      @(negedge clk_i);
      n_checks++;
      if (gnt_o !== ids[i]) begin
        n_fail++; $display("FAIL full_fill[%0d]: got %b expected %b", i, gnt_o, ids[i]);
      end
      advance();
    end
    req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      crv = (i == 1);
      @(negedge clk_i);
      n_checks++;
      if (cache_req_o !== 1'b0 || gnt_o !== 2'b00) begin
        n_fail++; $display("FAIL full_block[%0d]: got req=%b gnt=%b expected 0 00", i, cache_req_o, gnt_o);
      end
      if (i == 1) begin
        n_checks++;
        if (rvalid_o !== 2'b01) begin
          n_fail++; $display("FAIL full_pop0: got %b expected 01", rvalid_o);
        end
      end
      advance();
    end
    req = 2'b00; cgnt = 0; crv = 1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (rvalid_o !== ids[i]) begin
        n_fail++; $display("FAIL full_order[%0d]: got %b expected %b", i, rvalid_o, ids[i]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_simul();
    logic [1:0] ids [3];
    logic [1:0] drain [3];
    ids   = '{2'b01, 2'b10, 2'b01};
    drain = '{2'b10, 2'b01, 2'b10};
    cgnt = 1;
    for (int i = 0; i < 3; i++) begin
      req = ids[i];
      advance();
    end
    req = 2'b10; crv = 1;
    @(negedge clk_i);
    n_checks++;
    if (gnt_o !== 2'b10 || rvalid_o !== 2'b01) begin
      n_fail++; $display("FAIL simul_same_cycle: got gnt=%b rv=%b expected 10 01", gnt_o, rvalid_o);
    end
    advance();
    n_checks++;
    if (int'(dut.count_q) != 3) begin
      n_fail++; $display("FAIL simul_count: got %0d expected 3", dut.count_q);
    end
    req = 2'b00; cgnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (rvalid_o !== drain[i]) begin
        n_fail++; $display("FAIL simul_drain[%0d]: got %b expected %b", i, rvalid_o, drain[i]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_spurious_reset();
    crv = 1;
    @(negedge clk_i);
    n_checks++;
    if (rvalid_o !== 2'b00) begin
      n_fail++; $display("FAIL spur_rvalid: got %b expected 00", rvalid_o);
    end
    advance();
    n_checks++;
    if (dut.spurious_q !== 1'b1) begin
      n_fail++; $display("FAIL spur_flag: got %b expected 1", dut.spurious_q);
    end
    crv = 0; cgnt = 1;
    req = 2'b01; advance();
    req = 2'b10; advance();
    idle_inputs();
    crv = 1;
    rst_ni = 0;
    model_reset();
    @(negedge clk_i);
    n_checks++;
    if (int'(dut.count_q) != 0 || gnt_o !== 2'b00 || rvalid_o !== 2'b00) begin
      n_fail++; $display("FAIL midreset: got count=%0d gnt=%b rv=%b expected 0 00 00", dut.count_q, gnt_o, rvalid_o);
    end
    n_checks++;
    if (dut.spurious_q !== 1'b0) begin
      n_fail++; $display("FAIL midreset_spur: got %b expected 0", dut.spurious_q);
    end
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(negedge clk_i);
    n_checks++;
    if (rvalid_o !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_resp: got %b expected 00", rvalid_o);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req    = 2'($urandom);
      cgnt   = ($urandom_range(0, 3) != 0);
      crv    = ($urandom_range(0, 2) != 0);
      cerr   = 1'($urandom);
      crdata = $urandom;
      addr0  = $urandom; addr1 = $urandom;
      we     = 2'($urandom);
      be0    = 4'($urandom); be1 = 4'($urandom);
      wdata0 = $urandom; wdata1 = $urandom;
      @(negedge clk_i);
      predict();
      n_checks++;
      if (gnt_o !== exp_gnt || cache_req_o !== exp_creq || rvalid_o !== exp_rv) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got gnt=%b req=%b rv=%b expected %b %b %b", i, gnt_o, cache_req_o, rvalid_o, exp_gnt, exp_creq, exp_rv);
      end
      if (exp_creq) begin
        n_checks++;
        if (cache_addr_o !== (m_sel ? addr1 : addr0) || cache_we_o !== we[m_sel] ||
            cache_be_o !== (m_sel ? be1 : be0) || cache_wdata_o !== (m_sel ? wdata1 : wdata0)) begin
          n_fail++;
          $display("FAIL rand_fwd[%0d]: got addr=%h we=%b be=%h wd=%h for requester %0d", i, cache_addr_o, cache_we_o, cache_be_o, cache_wdata_o, m_sel);
        end
      end
      if (exp_rv != 2'b00) begin
        n_checks++;
        if (rdata_o !== crdata || err_o !== cerr) begin
          n_fail++; $display("FAIL rand_resp[%0d]: got %h/%b expected %h/%b", i, rdata_o, err_o, crdata, cerr);
        end
      end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_full();
    test_simul();
    test_spurious_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
